// File: rtl/sobel_stream.sv
// sobel_stream: raster-stream 3x3 Sobel stage with two internal line buffers,
// emitting saturated gradient magnitude, quantised direction and edge flag.
module sobel_stream #(
    parameter int DATA_WIDTH = 8,
    parameter int IMG_W = 640,
    parameter int IMG_H = 480,
    parameter int MAG_SHIFT = 3,
    parameter int THRESH = 15
) (
    input  logic                  clk,
    input  logic                  rst_b,
    input  logic                  in_valid,
    output logic                  in_ready,
    input  logic                  in_sof,
    input  logic [DATA_WIDTH-1:0] in_pix,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic [DATA_WIDTH-1:0] out_mag,
    output logic [1:0]            out_dir,
    output logic                  out_edge,
    output logic                  out_sof
);
    localparam int GW = DATA_WIDTH + 4;
    localparam int CW = $clog2(IMG_W);
    localparam int RW = $clog2(IMG_H);
    localparam logic [GW-1:0] MAG_MAX = {4'b0, {DATA_WIDTH{1'b1}}};

    logic advance, accept, s1Valid, s1Sof;
    logic [CW-1:0] col, curCol;
    logic [RW-1:0] row, curRow;
    logic [DATA_WIDTH-1:0] lineA [IMG_W];
    logic [DATA_WIDTH-1:0] lineB [IMG_W];
    logic [DATA_WIDTH-1:0] topWin [2];
    logic [DATA_WIDTH-1:0] midWin [2];
    logic [DATA_WIDTH-1:0] botWin [2];
    logic [DATA_WIDTH-1:0] topNew, midNew, magNext;
    logic signed [GW-1:0] gxNext, gyNext, gx, gy;
    logic [GW-1:0] ax, ay, absSum, shifted;
    logic [GW+2:0] ax2, ay2, ax5, ay5;
    logic [1:0] dirNext;

    function automatic logic signed [GW-1:0] ext(input logic [DATA_WIDTH-1:0] p);
        return $signed({4'b0, p});
    endfunction

    assign advance = !out_valid || out_ready;
    assign in_ready = rst_b && advance;
    assign accept = in_valid && in_ready;
    assign curCol = in_sof ? '0 : col;
    assign curRow = in_sof ? '0 : row;
    // lineA holds the previous row, lineB the row before that
    assign topNew = lineB[curCol];
    assign midNew = lineA[curCol];

    assign gxNext = ext(topNew) + (ext(midNew) <<< 1) + ext(in_pix)
                  - ext(topWin[0]) - (ext(midWin[0]) <<< 1) - ext(botWin[0]);
    assign gyNext = ext(topWin[0]) + (ext(topWin[1]) <<< 1) + ext(topNew)
                  - ext(botWin[0]) - (ext(botWin[1]) <<< 1) - ext(in_pix);

    assign ax = gx[GW-1] ? -gx : gx;
    assign ay = gy[GW-1] ? -gy : gy;
    assign absSum = ax + ay;
    assign shifted = absSum >> MAG_SHIFT;
    assign magNext = (shifted > MAG_MAX) ? MAG_MAX[DATA_WIDTH-1:0] : shifted[DATA_WIDTH-1:0];
    assign ax2 = {2'b0, ax, 1'b0};
    assign ay2 = {2'b0, ay, 1'b0};
    assign ax5 = {3'b0, ax} + {1'b0, ax, 2'b0};
    assign ay5 = {3'b0, ay} + {1'b0, ay, 2'b0};
    assign dirNext = (gx == 0 && gy == 0) ? 2'd0 :
                     (ay5 < ax2) ? 2'd0 :
                     (ax5 < ay2) ? 2'd2 :
                     (gx[GW-1] == gy[GW-1] && gx != 0 && gy != 0) ? 2'd1 : 2'd3;

    // Buffers and window need no reset: results are gated by row/col position
    always_ff @(posedge clk) begin
        if (accept) begin
            lineA[curCol] <= in_pix;
            lineB[curCol] <= midNew;
            topWin[0] <= topWin[1];
            midWin[0] <= midWin[1];
            botWin[0] <= botWin[1];
            topWin[1] <= topNew;
            midWin[1] <= midNew;
            botWin[1] <= in_pix;
        end
    end

    always_ff @(posedge clk or negedge rst_b) begin
        if (!rst_b) begin
            col <= '0;
            row <= '0;
            s1Valid <= 1'b0;
            s1Sof <= 1'b0;
            gx <= '0;
            gy <= '0;
            out_valid <= 1'b0;
            out_mag <= '0;
            out_dir <= '0;
            out_edge <= 1'b0;
            out_sof <= 1'b0;
        end else begin
            if (accept) begin
                col <= (curCol == CW'(IMG_W - 1)) ? '0 : curCol + 1'b1;
                row <= (curCol != CW'(IMG_W - 1)) ? curRow :
                       (curRow == RW'(IMG_H - 1)) ? '0 : curRow + 1'b1;
            end
            if (advance) begin
                s1Valid <= accept && curRow >= RW'(2) && curCol >= CW'(2);
                s1Sof <= curRow == RW'(2) && curCol == CW'(2);
                gx <= gxNext;
                gy <= gyNext;
                out_valid <= s1Valid;
                out_mag <= magNext;
                out_dir <= dirNext;
                out_edge <= magNext >= DATA_WIDTH'(THRESH);
                out_sof <= s1Valid && s1Sof;
            end
        end
    end
endmodule
